// File: rtl/bnn_bit_streamer_if.sv
// ----------------------------------------------------------------------------
// bnn_bit_streamer_if
//
// Bundles the word-side handshake and the three-wire serial stream of
// bnn_bit_streamer.
//
//   in_valid  producer -> streamer  word pair available
//   in_ready  streamer -> producer  streamer can accept a word pair
//   in_p      producer -> streamer  pixel word, sent LSB first
//   in_w      producer -> streamer  weight word, sent LSB first
//   out_p     streamer -> receiver  serial pixel bit
//   out_w     streamer -> receiver  serial weight bit
//   out_en    streamer -> receiver  bit strobe
//   busy      streamer -> producer  a word is being streamed
//   done      streamer -> producer  one-cycle pulse after the last hold phase
//
// Modports: master = producer / harness side, slave = the streamer itself.
// ----------------------------------------------------------------------------
interface bnn_bit_streamer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_p;
    logic [WIDTH-1:0] in_w;
    logic             out_p;
    logic             out_w;
    logic             out_en;
    logic             busy;
    logic             done;

    modport master (
        output in_valid,
        output in_p,
        output in_w,
        input  in_ready,
        input  out_p,
        input  out_w,
        input  out_en,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_p,
        input  in_w,
        output in_ready,
        output out_p,
        output out_w,
        output out_en,
        output busy,
        output done
    );
endinterface

// File: rtl/bnn_bit_streamer.sv
// ----------------------------------------------------------------------------
// bnn_bit_streamer
//
// Serializes a pixel/weight word pair into the bit-serial (p, w, en) stream
// consumed by the `pipe` synchronizer on the BNN core side. Each bit goes
// through three phases:
//   SETUP  : p/w driven, en=0, for SETUP_CYCLES cycles
//   STROBE : en=1, p/w steady, for STROBE_CYCLES cycles
//   HOLD   : en=0, p/w steady, for HOLD_CYCLES cycles
// The margins let a 2-FF synchronizer in an unrelated clock domain see
// exactly one rising edge of en per bit with p/w already settled.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      bnn_bit_streamer_if.slave (handshake, words, serial stream,
//            busy/done status)
//
// All outputs come straight from flops; nothing on the input side reaches
// out_* combinationally. A word accepted at edge k returns to IDLE at edge
// k + WIDTH*(SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES), with done high for
// the following cycle.
// ----------------------------------------------------------------------------
module bnn_bit_streamer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    bnn_bit_streamer_if.slave      bus
);

    // Phase counter must hold the longest phase length minus one.
    localparam int unsigned MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_PH = (STROBE_CYCLES > MAX_SH) ? STROBE_CYCLES : MAX_SH;
    localparam int unsigned PH_W   = $clog2(MAX_PH) + 1;
    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PH_W-1:0]  SETUP_LAST  = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0]  STROBE_LAST = PH_W'(STROBE_CYCLES - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST   = PH_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e           state_q;
    logic [PH_W-1:0]  ph_q;
    logic [IDX_W-1:0] idx_q;
    // Bits still to be sent; bit 0 is always the next one to drive.
    logic [WIDTH-1:0] p_sh_q;
    logic [WIDTH-1:0] w_sh_q;
    logic             p_q;
    logic             w_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ph_q    <= '0;
            idx_q   <= '0;
            p_sh_q  <= '0;
            w_sh_q  <= '0;
            p_q     <= 1'b0;
            w_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && ready_q) begin
                        // Bit 0 goes out immediately; the rest wait in the shifters.
                        p_q     <= bus.in_p[0];
                        w_q     <= bus.in_w[0];
                        p_sh_q  <= bus.in_p >> 1;
                        w_sh_q  <= bus.in_w >> 1;
                        idx_q   <= '0;
                        ph_q    <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (ph_q == SETUP_LAST) begin
                        ph_q    <= '0;
                        en_q    <= 1'b1;
                        state_q <= StStrobe;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                StStrobe: begin
                    if (ph_q == STROBE_LAST) begin
                        ph_q    <= '0;
                        en_q    <= 1'b0;
                        state_q <= StHold;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                StHold: begin
                    if (ph_q == HOLD_LAST) begin
                        ph_q <= '0;
                        if (idx_q != LAST_IDX) begin
                            // Data only changes here, on entry to SETUP.
                            idx_q   <= idx_q + IDX_W'(1);
                            p_q     <= p_sh_q[0];
                            w_q     <= w_sh_q[0];
                            p_sh_q  <= p_sh_q >> 1;
                            w_sh_q  <= w_sh_q >> 1;
                            state_q <= StSetup;
                        end else begin
                            p_q     <= 1'b0;
                            w_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.out_p    = p_q;
    assign bus.out_w    = w_q;
    assign bus.out_en   = en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.in_ready = ready_q;

endmodule

// File: tb/tb_bnn_bit_streamer.sv
// ----------------------------------------------------------------------------
// tb_bnn_bit_streamer
//
// Directed bench for bnn_bit_streamer with default parameters (WIDTH=8,
// 2/3/2 cycle phases, bit period 7, word period 56). Outputs are sampled
// 1 time unit after each rising edge; offset j means "just after edge k+j"
// where k is the acceptance edge. A 2-FF synchronizer plus edge-triggered
// shift receiver on the same clock stands in for `pipe` for the loopback.
// ----------------------------------------------------------------------------
module tb_bnn_bit_streamer;

    localparam int unsigned W  = 8;
    localparam int unsigned SU = 2;
    localparam int unsigned ST = 3;
    localparam int unsigned HO = 2;
    localparam int          P  = 7;
    localparam int          WP = 56;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bnn_bit_streamer_if #(.WIDTH(W)) bus ();

    bnn_bit_streamer #(
        .WIDTH        (W),
        .SETUP_CYCLES (SU),
        .STROBE_CYCLES(ST),
        .HOLD_CYCLES  (HO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: 2-FF synchronizer, shift on rising edge of synced en.
    logic [2:0]   s1 = '0;
    logic [2:0]   s2 = '0;
    logic         en_d = 1'b0;
    logic [W-1:0] rx_p = '0;
    logic [W-1:0] rx_w = '0;
    int           rx_cnt = 0;

    always @(posedge clk) begin
        s1   <= {bus.out_p, bus.out_w, bus.out_en};
        s2   <= s1;
        en_d <= s2[0];
        if (s2[0] && !en_d) begin
            rx_p   <= {s2[2], rx_p[W-1:1]};
            rx_w   <= {s2[1], rx_w[W-1:1]};
            rx_cnt <= rx_cnt + 1;
        end
    end

    // Per-offset sample history.
    logic hp[256], hw[256], hen[256], hbusy[256], hdone[256], hrdy[256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] p, input logic [7:0] w, input bit keep);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_p     = p;
        bus.in_w     = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.in_ready === 1'b1) ok = 1'b1;
            tick();
        end
        if (!keep) bus.in_valid = 1'b0;
        check_val("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic capture(input int n, input int drop_at);
        for (int j = 0; j < n; j++) begin
            hp[j]    = bus.out_p;
            hw[j]    = bus.out_w;
            hen[j]   = bus.out_en;
            hbusy[j] = bus.busy;
            hdone[j] = bus.done;
            hrdy[j]  = bus.in_ready;
            if (j == drop_at) bus.in_valid = 1'b0;
            tick();
        end
    endtask

    // Timing model: bit b occupies offsets 7b..7b+6, strobe on phase 2..4.
    task automatic check_word(input int base, input logic [7:0] p, input logic [7:0] w,
                              input string tag);
        for (int j = 0; j < WP; j++) begin
            int b;
            int ph;
            b  = j / P;
            ph = j % P;
            check_val($sformatf("%s_en@%0d", tag, j), {31'd0, hen[base+j]},
                      (ph >= SU && ph < SU + ST) ? 32'd1 : 32'd0);
            check_val($sformatf("%s_p@%0d", tag, j), {31'd0, hp[base+j]}, {31'd0, p[b]});
            check_val($sformatf("%s_w@%0d", tag, j), {31'd0, hw[base+j]}, {31'd0, w[b]});
            check_val($sformatf("%s_busy@%0d", tag, j), {31'd0, hbusy[base+j]}, 32'd1);
            check_val($sformatf("%s_rdy@%0d", tag, j), {31'd0, hrdy[base+j]}, 32'd0);
            check_val($sformatf("%s_done@%0d", tag, j), {31'd0, hdone[base+j]}, 32'd0);
        end
        check_val({tag, "_end_done"}, {31'd0, hdone[base+WP]}, 32'd1);
        check_val({tag, "_end_rdy"},  {31'd0, hrdy[base+WP]},  32'd1);
        check_val({tag, "_end_busy"}, {31'd0, hbusy[base+WP]}, 32'd0);
        check_val({tag, "_end_p"},    {31'd0, hp[base+WP]},    32'd0);
        check_val({tag, "_end_w"},    {31'd0, hw[base+WP]},    32'd0);
        check_val({tag, "_end_en"},   {31'd0, hen[base+WP]},   32'd0);
    endtask

    task automatic check_framing(input int n, input int exp_rises, input string tag);
        int rises;
        int run;
        int bad_run;
        int bad_tog;
        rises = 0; run = 0; bad_run = 0; bad_tog = 0;
        for (int j = 0; j < n; j++) begin
            if (hen[j] && (j == 0 || !hen[j-1])) rises++;
            if (hen[j]) run++;
            else begin
                if (run != 0 && run != ST) bad_run++;
                run = 0;
            end
            if (j >= 2 && ((hp[j] !== hp[j-1]) || (hw[j] !== hw[j-1])) &&
                (hen[j] || hen[j-1] || hen[j-2])) bad_tog++;
        end
        check_val({tag, "_rises"}, rises, exp_rises);
        check_val({tag, "_runlen"}, bad_run, 0);
        check_val({tag, "_toggle"}, bad_tog, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rp;
        logic [7:0] rw;
        int base;
        bit found;

        // Reset with in_valid asserted: nothing may be accepted.
        bus.in_valid = 1'b1;
        bus.in_p     = 8'hFF;
        bus.in_w     = 8'hFF;
        reset_n      = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_p",    {31'd0, bus.out_p},    32'd0);
        check_val("rst_w",    {31'd0, bus.out_w},    32'd0);
        check_val("rst_en",   {31'd0, bus.out_en},   32'd0);
        check_val("rst_busy", {31'd0, bus.busy},     32'd0);
        check_val("rst_done", {31'd0, bus.done},     32'd0);
        check_val("rst_rdy",  {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        tick();
        check_val("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        // Single word A5/3C with hand-computed landmarks.
        accept(8'hA5, 8'h3C, 1'b0);
        capture(58, -1);
        check_val("sw_b0_p",     {31'd0, hp[0]},    32'd1);
        check_val("sw_b0_w",     {31'd0, hw[0]},    32'd0);
        check_val("sw_en_k1",    {31'd0, hen[1]},   32'd0);
        check_val("sw_en_k2",    {31'd0, hen[2]},   32'd1);
        check_val("sw_en_k4",    {31'd0, hen[4]},   32'd1);
        check_val("sw_en_k5",    {31'd0, hen[5]},   32'd0);
        check_val("sw_b1_p",     {31'd0, hp[7]},    32'd0);
        check_val("sw_b1_w",     {31'd0, hw[7]},    32'd0);
        check_val("sw_done_k56", {31'd0, hdone[56]}, 32'd1);
        check_val("sw_rdy_k56",  {31'd0, hrdy[56]},  32'd1);
        check_val("sw_done_k57", {31'd0, hdone[57]}, 32'd0);
        check_word(0, 8'hA5, 8'h3C, "sw");
        check_framing(58, 8, "sw_frm");

        // Back-to-back: valid held; data changed while busy must be ignored
        // for the first word and picked up by the second.
        accept(8'hFF, 8'h00, 1'b1);
        bus.in_p = 8'h00;
        bus.in_w = 8'hFF;
        capture(115, 113);
        check_word(0, 8'hFF, 8'h00, "b2b_a");
        check_val("b2b_acc_rdy",  {31'd0, hrdy[57]},  32'd0);
        check_val("b2b_acc_busy", {31'd0, hbusy[57]}, 32'd1);
        check_val("b2b_acc_p",    {31'd0, hp[57]},    32'd0);
        check_val("b2b_acc_w",    {31'd0, hw[57]},    32'd1);
        check_word(57, 8'h00, 8'hFF, "b2b_b");
        check_val("b2b_done_k114", {31'd0, hdone[114]}, 32'd0);
        check_val("b2b_idle_k114", {31'd0, hbusy[114]}, 32'd0);
        check_framing(115, 16, "b2b_frm");

        // Reset during the bit-3 strobe: en must drop with no clock edge.
        accept(8'h33, 8'h0F, 1'b0);
        repeat (24) tick();
        check_val("mid_en_before", {31'd0, bus.out_en}, 32'd1);
        check_val("mid_w_before",  {31'd0, bus.out_w},  32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_en_async",   {31'd0, bus.out_en},   32'd0);
        check_val("mid_w_async",    {31'd0, bus.out_w},    32'd0);
        check_val("mid_busy_async", {31'd0, bus.busy},     32'd0);
        check_val("mid_rdy_async",  {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check_val("mid_rdy_release", {31'd0, bus.in_ready}, 32'd1);
        accept(8'h5A, 8'hC3, 1'b0);
        capture(58, -1);
        check_word(0, 8'h5A, 8'hC3, "mid");
        check_framing(58, 8, "mid_frm");

        // Loopback through the synchronizer/receiver model.
        for (int i = 0; i < 16; i++) begin
            rp   = 8'($urandom_range(0, 255));
            rw   = 8'($urandom_range(0, 255));
            base = rx_cnt;
            accept(rp, rw, 1'b0);
            found = 1'b0;
            for (int c = 0; c < 100 && !found; c++) begin
                if (bus.done === 1'b1) found = 1'b1;
                else tick();
            end
            check_val($sformatf("lb%0d_done", i), {31'd0, found}, 32'd1);
            repeat (4) tick();
            check_val($sformatf("lb%0d_p", i), {24'd0, rx_p}, {24'd0, rp});
            check_val($sformatf("lb%0d_w", i), {24'd0, rx_w}, {24'd0, rw});
            check_val($sformatf("lb%0d_bits", i), rx_cnt - base, 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
